// File: rtl/cpu_regfile_pkg.sv
// rtl/cpu_regfile_pkg.sv - shared constants, types and width helper for the register file
// Purpose: default geometry of the register file and the busy-count width function.
// Ports: none (package).
package cpu_regfile_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;

  // Width needed to count 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  typedef logic [$clog2(DEF_NREG)-1:0] reg_addr_t;
  typedef logic [DEF_XLEN-1:0]         reg_data_t;

endpackage

// File: rtl/cpu_regfile_scoreboard.sv
// rtl/cpu_regfile_scoreboard.sv - busy-bit vector with a running popcount
// Purpose: tracks registers with an outstanding producer. A set and a clear
//   to the same register in one cycle leave the bit set (the new producer wins).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   set_en, set_addr    mark a register busy (caller guarantees a valid address)
//   clr_en, clr_addr    clear a register's busy bit (caller guarantees a valid address)
//   busy                current busy vector
//   busy_cnt            number of set bits in busy
module cpu_regfile_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int CW   = $clog2(NREG + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  logic [AW-1:0]   set_addr,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_addr,
  output logic [NREG-1:0] busy,
  output logic [CW-1:0]   busy_cnt
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   busy_cnt_q, busy_cnt_d;
  logic            set_new;
  logic            clr_old;

  always_comb begin
    busy_d  = busy_q;
    set_new = 1'b0;
    clr_old = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (clr_en && clr_addr == AW'(i)) begin
        busy_d[i] = 1'b0;
        clr_old   = busy_q[i];
      end
      // Applied after the clear so a same-cycle mark supersedes it.
      if (set_en && set_addr == AW'(i)) begin
        busy_d[i] = 1'b1;
        set_new   = ~busy_q[i];
      end
    end
    // Same-address set+clear: bit ends up 1, so a previously set bit is not lost.
    if (set_en && clr_en && set_addr == clr_addr) begin
      clr_old = 1'b0;
    end
    busy_cnt_d = busy_cnt_q + CW'(set_new) - CW'(clr_old);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/cpu_regfile_sb.sv
// rtl/cpu_regfile_sb.sv - multi-read-port register file with busy scoreboard
// Purpose: NRD combinational read ports with per-operand busy status, one
//   writeback port that also retires the busy bit, one issue-side mark port.
//   Register 0 and out-of-range addresses read as zero and never busy.
// Configuration: define REGFILE_BYPASS_EN to forward the writeback data
//   (and a cleared busy) to matching read ports in the same cycle.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   raddr / rdata / rbusy      read ports, port i at [i*AW +: AW] / [i*XLEN +: XLEN] / [i]
//   we, waddr, wdata           writeback
//   mark_en, mark_addr         mark a register busy
//   busy_cnt                   number of busy registers
module cpu_regfile_sb
  import cpu_regfile_pkg::*;
#(
  parameter int  XLEN = DEF_XLEN,
  parameter int  NREG = DEF_NREG,
  parameter int  NRD  = 2,
  localparam int AW   = $clog2(NREG),
  localparam int CW   = cnt_width(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic              mark_en,
  input  logic [AW-1:0]     mark_addr,
  output logic [CW-1:0]     busy_cnt
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy;
  logic            wr_ok;
  logic            mark_ok;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < NREG);
  endfunction

  assign wr_ok   = we && addr_ok(waddr);
  assign mark_ok = mark_en && addr_ok(mark_addr);

  cpu_regfile_scoreboard #(
    .NREG (NREG),
    .AW   (AW),
    .CW   (CW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (mark_ok),
    .set_addr (mark_addr),
    .clr_en   (wr_ok),
    .clr_addr (waddr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  // Entry 0 is never written, so it holds its reset value of zero.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    for (int i = 1; i < NREG; i++) begin
      if (wr_ok && waddr == AW'(i)) begin
        regs_d[i] = wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int p = 0; p < NRD; p++) begin
      if (addr_ok(raddr[p*AW +: AW])) begin
        for (int i = 1; i < NREG; i++) begin
          if (raddr[p*AW +: AW] == AW'(i)) begin
            rdata[p*XLEN +: XLEN] = regs_q[i];
            rbusy[p]              = busy[i];
          end
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && waddr == raddr[p*AW +: AW]) begin
          rdata[p*XLEN +: XLEN] = wdata;
          rbusy[p]              = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_cpu_regfile_sb.sv
// tb/tb_cpu_regfile_sb.sv - randomized self-checking bench for cpu_regfile_sb
module tb_cpu_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;
  localparam int CW   = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]    rbusy;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [XLEN-1:0]   wdata;
  logic              mark_en;
  logic [AW-1:0]     mark_addr;
  logic [CW-1:0]     busy_cnt;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  // Reference state: architectural values and pending-producer flags.
  int unsigned m_regs [NREG];
  bit          m_busy [NREG];

  cpu_regfile_sb #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRD  (NRD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .mark_en   (mark_en),
    .mark_addr (mark_addr),
    .busy_cnt  (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = 0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic int unsigned model_count();
    int unsigned n = 0;
    for (int i = 0; i < NREG; i++) n += m_busy[i];
    return n;
  endfunction

  function automatic logic [31:0] exp_rdata(input int a);
    if (a == 0 || a >= NREG) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && int'(waddr) == a) return wdata;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_rbusy(input int a);
    if (a == 0 || a >= NREG) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we && int'(waddr) == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  // Applies the architectural effect of one clock edge.
  function automatic void model_edge();
    if (we && waddr != 0) begin
      m_regs[waddr] = wdata;
      m_busy[waddr] = 1'b0;
    end
    if (mark_en && mark_addr != 0) m_busy[mark_addr] = 1'b1;
  endfunction

  task automatic check_ports(input string tag);
    for (int p = 0; p < NRD; p++) begin
      check($sformatf("%s_rdata%0d", tag, p), 64'(rdata[p*XLEN +: XLEN]),
            64'(exp_rdata(int'(raddr[p*AW +: AW]))));
      check($sformatf("%s_rbusy%0d", tag, p), 64'(rbusy[p]),
            64'(exp_rbusy(int'(raddr[p*AW +: AW]))));
    end
    check($sformatf("%s_cnt", tag), 64'(busy_cnt), 64'(model_count()));
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #2;
    check_ports("step");
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0; mark_en = 1'b0; mark_addr = '0; raddr = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();

    // 1: reset state on every address and both ports
    for (int a = 0; a < NREG; a++) begin
      raddr = {AW'(a), AW'(NREG - 1 - a)};
      #1;
      check_ports("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;

    // 2: write r5, read on both ports; r0 ignores writes
    we = 1'b1; waddr = 5; wdata = 32'hDEADBEEF;
    step();
    we = 1'b0; raddr = {AW'(5), AW'(5)};
    #1;
    check("r5_port0", 64'(rdata[31:0]), 64'hDEADBEEF);
    check("r5_port1", 64'(rdata[63:32]), 64'hDEADBEEF);
    we = 1'b1; waddr = 0; wdata = 7;
    step();
    we = 1'b0; raddr = '0;
    #1;
    check("r0_zero", 64'(rdata[31:0]), 64'h0);

    // 3: marks and retire
    mark_en = 1'b1; mark_addr = 3;
    step();
    check("cnt_after_r3", 64'(busy_cnt), 64'd1);
    mark_addr = 4;
    step();
    check("cnt_after_r4", 64'(busy_cnt), 64'd2);
    mark_en = 1'b0; we = 1'b1; waddr = 3; wdata = 49;
    step();
    we = 1'b0; raddr = {AW'(4), AW'(3)};
    #1;
    check("r3_busy", 64'(rbusy[0]), 64'd0);
    check("r4_busy", 64'(rbusy[1]), 64'd1);
    check("r3_data", 64'(rdata[31:0]), 64'd49);
    check("cnt_after_wr3", 64'(busy_cnt), 64'd1);

    // 4: mark and write same register; mark one while retiring another
    mark_en = 1'b1; mark_addr = 6; we = 1'b1; waddr = 6; wdata = 2;
    step();
    we = 1'b0; mark_en = 1'b0; raddr = {AW'(0), AW'(6)};
    #1;
    check("r6_data", 64'(rdata[31:0]), 64'd2);
    check("r6_busy", 64'(rbusy[0]), 64'd1);
    check("cnt_r6", 64'(busy_cnt), 64'd2);
    mark_en = 1'b1; mark_addr = 8;
    step();
    mark_addr = 7; we = 1'b1; waddr = 8; wdata = 32'h88;
    step();
    we = 1'b0; mark_en = 1'b0;
    #1;
    check("cnt_r7_r8", 64'(busy_cnt), 64'd3);

    // 5: same-cycle visibility of a write
    we = 1'b1; waddr = 9; wdata = 32'h1234; raddr = {AW'(0), AW'(9)};
    #1;
`ifdef REGFILE_BYPASS_EN
    check("r9_same_cycle", 64'(rdata[31:0]), 64'h1234);
`else
    check("r9_same_cycle", 64'(rdata[31:0]), 64'h0);
`endif
    step();
    we = 1'b0;
    #1;
    check("r9_next_cycle", 64'(rdata[31:0]), 64'h1234);

    // Randomized traffic; narrow address range half the time to force aliasing
    for (int n = 0; n < 400; n++) begin
      int unsigned hi;
      hi = ($urandom_range(0, 1) == 1) ? 7 : NREG - 1;
      raddr     = {AW'($urandom_range(0, hi)), AW'($urandom_range(0, hi))};
      we        = ($urandom_range(0, 2) != 0);
      waddr     = AW'($urandom_range(0, hi));
      wdata     = $urandom;
      mark_en   = ($urandom_range(0, 2) != 0);
      mark_addr = AW'($urandom_range(0, hi));
      step();
    end

    // 6: reset between edges clears everything immediately
    idle_inputs();
    for (int r = 10; r <= 12; r++) begin
      mark_en = 1'b1; mark_addr = AW'(r);
      step();
    end
    mark_en = 1'b0; we = 1'b1; waddr = 2; wdata = 5;
    step();
    we = 1'b0; raddr = {AW'(10), AW'(2)};
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_cnt", 64'(busy_cnt), 64'd0);
    check("rst_r2", 64'(rdata[31:0]), 64'd0);
    check("rst_r10_busy", 64'(rbusy[1]), 64'd0);
    #1;
    rst_n = 1'b1;
    we = 1'b1; waddr = 2; wdata = 32'hA5A5;
    mark_en = 1'b1; mark_addr = 11;
    step();
    idle_inputs();
    raddr = {AW'(11), AW'(2)};
    #1;
    check("post_rst_r2", 64'(rdata[31:0]), 64'hA5A5);
    check("post_rst_cnt", 64'(busy_cnt), 64'd1);
    check_ports("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
